// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//
// Load/store initiator between the RV32I execute stage and a byte-enable
// word RAM with a one-cycle registered read. It accepts one request at a
// time, converts the byte address to a word index, and drives byte enables
// with lane-replicated store data. Loads are shifted and sign- or
// zero-extended. Misaligned, out-of-range and illegal-width requests get a
// fault response and never touch memory.
//
// Ports
//   clk, rst (sync, active-low), clk_en (global enable shared with the RAM)
//   i_req_*            request channel (valid/ready, we, funct3, addr, wdata)
//   o_rsp_* / i_rsp_*  response channel (valid/ready, rdata, fault code)
//   o_mem_read_*       RAM read port (enable, word index; data back next cycle)
//   o_mem_write_*      RAM write port (byte enables, word index, data)
//
// Fault codes: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
module lsu_mem_port #(
    parameter int ADDR_WIDTH  = 31,
    parameter int DATA_WIDTH  = 31,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic [1:0]            o_rsp_fault,
    output logic                  o_mem_read_enable,
    output logic [ADDR_WIDTH:0]   o_mem_read_addr,
    input  logic [DATA_WIDTH:0]   i_mem_read_data,
    output logic [3:0]            o_mem_write_enable,
    output logic [ADDR_WIDTH:0]   o_mem_write_addr,
    output logic [DATA_WIDTH:0]   o_mem_write_data
);

    localparam int AW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  req_funct3;
    logic [1:0]  req_off;

    logic        funct3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  req_fault;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [31:0] rd_shifted;
    logic [31:0] load_value;

    // Ready depends on rst directly so it drops in the same cycle reset is held.
    assign o_req_ready = rst && (state == IDLE);

    // Classify the incoming request; illegal width outranks misalignment,
    // which outranks the range check.
    always_comb begin
        funct3_ok = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !i_req_we;
            default:                funct3_ok = 1'b0;
        endcase
        misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, i_req_addr[31:2]} >= DEPTH_WORDS;
        if (!funct3_ok)
            req_fault = 2'b11;
        else if (misaligned)
            req_fault = 2'b01;
        else if (out_of_range)
            req_fault = 2'b10;
        else
            req_fault = 2'b00;
    end

    // Stores replicate the low bytes into every lane so the byte enables
    // alone select where the data lands.
    always_comb begin
        case (i_req_funct3[1:0])
            2'b00: begin
                store_data = {4{i_req_wdata[7:0]}};
                store_be   = 4'b0001 << i_req_addr[1:0];
            end
            2'b01: begin
                store_data = {2{i_req_wdata[15:0]}};
                store_be   = i_req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = i_req_wdata;
                store_be   = 4'b1111;
            end
        endcase
    end

    // Align the addressed byte/halfword to bit 0, then extend by width code.
    always_comb begin
        rd_shifted = i_mem_read_data >> {req_off, 3'b000};
        case (req_funct3)
            3'b000:  load_value = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_value = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_value = {24'h000000, rd_shifted[7:0]};
            3'b101:  load_value = {16'h0000, rd_shifted[15:0]};
            default: load_value = rd_shifted;
        endcase
    end

    // Memory enables are pulsed for exactly one enabled cycle in the issuing
    // state; everything holds while clk_en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            req_funct3         <= '0;
            req_off            <= '0;
            o_rsp_valid        <= 1'b0;
            o_rsp_rdata        <= '0;
            o_rsp_fault        <= '0;
            o_mem_read_enable  <= 1'b0;
            o_mem_read_addr    <= '0;
            o_mem_write_enable <= '0;
            o_mem_write_addr   <= '0;
            o_mem_write_data   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        req_funct3 <= i_req_funct3;
                        req_off    <= i_req_addr[1:0];
                        if (req_fault != 2'b00) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_fault <= req_fault;
                            o_rsp_rdata <= '0;
                        end else if (i_req_we) begin
                            state              <= WR;
                            o_mem_write_enable <= store_be;
                            o_mem_write_addr   <= AW'(i_req_addr[31:2]);
                            o_mem_write_data   <= store_data;
                        end else begin
                            state             <= RD_ISSUE;
                            o_mem_read_enable <= 1'b1;
                            o_mem_read_addr   <= AW'(i_req_addr[31:2]);
                        end
                    end
                end
                RD_ISSUE: begin
                    o_mem_read_enable <= 1'b0;
                    state             <= RD_DATA;
                end
                RD_DATA: begin
                    o_rsp_rdata <= load_value;
                    o_rsp_fault <= 2'b00;
                    o_rsp_valid <= 1'b1;
                    state       <= RESP;
                end
                WR: begin
                    o_mem_write_enable <= '0;
                    o_rsp_rdata        <= '0;
                    o_rsp_fault        <= 2'b00;
                    o_rsp_valid        <= 1'b1;
                    state              <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port
//
// Self-checking bench for lsu_mem_port. A behavioural byte-enable RAM with a
// registered read sits on the memory ports. Table vectors drive one request
// each; expected responses go into a scoreboard queue when the request is
// driven and are popped when the response appears. Hand-written sequences
// cover reset, back-pressure with clk_en stalls, and reset mid-load.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_fault;
    logic        o_mem_read_enable;
    logic [31:0] o_mem_read_addr;
    logic [31:0] i_mem_read_data;
    logic [3:0]  o_mem_write_enable;
    logic [31:0] o_mem_write_addr;
    logic [31:0] o_mem_write_data;

    lsu_mem_port dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_we           (i_req_we),
        .i_req_funct3       (i_req_funct3),
        .i_req_addr         (i_req_addr),
        .i_req_wdata        (i_req_wdata),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_rdata        (o_rsp_rdata),
        .o_rsp_fault        (o_rsp_fault),
        .o_mem_read_enable  (o_mem_read_enable),
        .o_mem_read_addr    (o_mem_read_addr),
        .i_mem_read_data    (i_mem_read_data),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_write_addr   (o_mem_write_addr),
        .o_mem_write_data   (o_mem_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, per-byte write, both gated by clk_en.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (clk_en) begin
            if (o_mem_read_enable)
                i_mem_read_data <= mem[o_mem_read_addr[10:0]];
            for (int b = 0; b < 4; b++)
                if (o_mem_write_enable[b])
                    mem[o_mem_write_addr[10:0]][8*b +: 8] <= o_mem_write_data[8*b +: 8];
        end
    end

    // Memory-port monitor: counts enabled cycles and remembers the last
    // values seen on each port.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [31:0] last_raddr;
    always @(negedge clk) begin
        if (o_mem_write_enable != 4'b0000) begin
            wr_cnt     <= wr_cnt + 1;
            last_be    <= o_mem_write_enable;
            last_waddr <= o_mem_write_addr;
            last_wdata <= o_mem_write_data;
        end
        if (o_mem_read_enable) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= o_mem_read_addr;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_bus;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        string       name;
    } exp_rsp_t;

    vec_t     vecs[$];
    exp_rsp_t sb[$];
    int       checks = 0;
    int       errors = 0;

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expected response and compare it with the live outputs.
    task automatic checkOutput();
        exp_rsp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got response, expected none");
            return;
        end
        e = sb.pop_front();
        expectEq({e.name, "_valid"}, 32'(o_rsp_valid), 32'd1);
        expectEq({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
        expectEq({e.name, "_fault"}, 32'(o_rsp_fault), 32'(e.fault));
    endtask

    // Drive one request, check latency, memory-port activity and response.
    task automatic applyStimulus(input vec_t v);
        int        lat;
        int        wr0;
        int        rd0;
        int        exp_lat;
        logic      ok;
        exp_rsp_t  e;
        ok      = (v.exp_fault == 2'b00);
        exp_lat = !ok ? 0 : (v.we ? 1 : 2);
        @(negedge clk);
        expectEq({v.name, "_ready"}, 32'(o_req_ready), 32'd1);
        wr0          = wr_cnt;
        rd0          = rd_cnt;
        i_req_valid  = 1'b1;
        i_req_we     = v.we;
        i_req_funct3 = v.f3;
        i_req_addr   = v.addr;
        i_req_wdata  = v.wdata;
        e.rdata = v.exp_rdata;
        e.fault = v.exp_fault;
        e.name  = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        lat = 0;
        while (!o_rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        expectEq({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        checkOutput();
        expectEq({v.name, "_wr_cycles"}, 32'(wr_cnt - wr0), (ok && v.we) ? 32'd1 : 32'd0);
        expectEq({v.name, "_rd_cycles"}, 32'(rd_cnt - rd0), (ok && !v.we) ? 32'd1 : 32'd0);
        if (ok && v.we) begin
            expectEq({v.name, "_be"}, 32'(last_be), 32'(v.exp_be));
            expectEq({v.name, "_waddr"}, last_waddr, {2'b00, v.addr[31:2]});
            expectEq({v.name, "_wdata"}, last_wdata, v.exp_bus);
        end
        if (ok && !v.we)
            expectEq({v.name, "_raddr"}, last_raddr, {2'b00, v.addr[31:2]});
    endtask

    task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [1:0] fault, input logic [3:0] be,
                          input logic [31:0] bus, input string name);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_fault = fault; v.exp_be = be; v.exp_bus = bus;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        vec_t v;

        //      we    f3      addr          wdata         rdata         flt    be       bus
        addVec(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2'b00, 4'b1111, 32'hDEAD_BEEF, "sw_10");
        addVec(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2'b00, 4'b0000, 32'h0,        "lw_10");
        addVec(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0,        2'b00, 4'b1000, 32'hA5A5_A5A5, "sb_13");
        addVec(1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFA5, 2'b00, 4'b0000, 32'h0,        "lb_13");
        addVec(1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00A5, 2'b00, 4'b0000, 32'h0,        "lbu_13");
        addVec(1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 2'b00, 4'b0000, 32'h0,        "lb_10");
        addVec(1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00BE, 2'b00, 4'b0000, 32'h0,        "lbu_11");
        addVec(1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 2'b00, 4'b0000, 32'h0,        "lhu_10");
        addVec(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hA5AD_BEEF, 2'b00, 4'b0000, 32'h0,        "lw_10_merged");
        addVec(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001, 32'h0,        2'b00, 4'b1100, 32'h8001_8001, "sh_22");
        addVec(1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'hFFFF_8001, 2'b00, 4'b0000, 32'h0,        "lh_22");
        addVec(1'b0, 3'b101, 32'h0000_0022, 32'h0,         32'h0000_8001, 2'b00, 4'b0000, 32'h0,        "lhu_22");
        addVec(1'b1, 3'b010, 32'h0000_1FFC, 32'h1234_5678, 32'h0,        2'b00, 4'b1111, 32'h1234_5678, "sw_last");
        addVec(1'b0, 3'b010, 32'h0000_1FFC, 32'h0,         32'h1234_5678, 2'b00, 4'b0000, 32'h0,        "lw_last");
        addVec(1'b0, 3'b001, 32'h0000_1FFE, 32'h0,         32'h0000_1234, 2'b00, 4'b0000, 32'h0,        "lh_last_hi");
        addVec(1'b0, 3'b000, 32'h0000_1FFF, 32'h0,         32'h0000_0012, 2'b00, 4'b0000, 32'h0,        "lb_last_b3");
        addVec(1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,        2'b01, 4'b0000, 32'h0,        "lw_misaligned");
        addVec(1'b1, 3'b010, 32'h0000_2000, 32'hFFFF_FFFF, 32'h0,        2'b10, 4'b0000, 32'h0,        "sw_range");
        addVec(1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        2'b11, 4'b0000, 32'h0,        "ld_f3_011");
        addVec(1'b1, 3'b001, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0,        2'b01, 4'b0000, 32'h0,        "sh_misaligned");
        addVec(1'b1, 3'b100, 32'h0000_4001, 32'hFFFF_FFFF, 32'h0,        2'b11, 4'b0000, 32'h0,        "st_f3_100_prio");
        addVec(1'b0, 3'b001, 32'h0000_2001, 32'h0,         32'h0,        2'b01, 4'b0000, 32'h0,        "lh_mis_over_range");
        addVec(1'b0, 3'b100, 32'h0000_2000, 32'h0,         32'h0,        2'b10, 4'b0000, 32'h0,        "lbu_range");
        addVec(1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF3C, 32'h0,        2'b00, 4'b0010, 32'h3C3C_3C3C, "sb_11");
        addVec(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hA5AD_3CEF, 2'b00, 4'b0000, 32'h0,        "lw_10_after_sb");

        // Reset held with a valid request pending: nothing may be accepted.
        rst          = 1'b0;
        clk_en       = 1'b1;
        i_rsp_ready  = 1'b1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        i_req_wdata  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expectEq("rst_ready",   32'(o_req_ready), 32'd0);
        expectEq("rst_valid",   32'(o_rsp_valid), 32'd0);
        expectEq("rst_rdata",   o_rsp_rdata, 32'd0);
        expectEq("rst_fault",   32'(o_rsp_fault), 32'd0);
        expectEq("rst_rd_en",   32'(o_mem_read_enable), 32'd0);
        expectEq("rst_rd_addr", o_mem_read_addr, 32'd0);
        expectEq("rst_wr_en",   32'(o_mem_write_enable), 32'd0);
        expectEq("rst_wr_addr", o_mem_write_addr, 32'd0);
        expectEq("rst_wr_data", o_mem_write_data, 32'd0);
        i_req_valid = 1'b0;
        rst         = 1'b1;
        #1;
        expectEq("rst_release_ready", 32'(o_req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        // Back-pressure: load stalled by clk_en during RD_ISSUE, then held
        // for five cycles with i_rsp_ready low.
        @(negedge clk);
        i_rsp_ready  = 1'b0;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        begin
            exp_rsp_t e;
            e.rdata = 32'hA5AD_3CEF;
            e.fault = 2'b00;
            e.name  = "bp_lw";
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        expectEq("bp_stall_rd_en", 32'(o_mem_read_enable), 32'd1);
        expectEq("bp_stall_valid", 32'(o_rsp_valid), 32'd0);
        @(negedge clk);
        clk_en = 1'b1;
        lat = 0;
        while (!o_rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        expectEq("bp_latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            expectEq("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
            expectEq("bp_hold_rdata", o_rsp_rdata, 32'hA5AD_3CEF);
            expectEq("bp_hold_ready", 32'(o_req_ready), 32'd0);
        end
        @(negedge clk);
        clk_en      = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        expectEq("bp_gated_handshake", 32'(o_rsp_valid), 32'd1);
        @(negedge clk);
        clk_en = 1'b1;
        checkOutput();
        @(posedge clk);
        #1;
        expectEq("bp_done_valid", 32'(o_rsp_valid), 32'd0);
        expectEq("bp_done_ready", 32'(o_req_ready), 32'd1);

        // Reset mid-load: the load is abandoned and never responds.
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expectEq("midrst_rd_en", 32'(o_mem_read_enable), 32'd0);
        expectEq("midrst_ready", 32'(o_req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            expectEq("midrst_no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        expectEq("midrst_ready_after", 32'(o_req_ready), 32'd1);

        v.we = 1'b0; v.f3 = 3'b010; v.addr = 32'h1FFC; v.wdata = 32'h0;
        v.exp_rdata = 32'h1234_5678; v.exp_fault = 2'b00; v.exp_be = 4'b0000;
        v.exp_bus = 32'h0; v.name = "lw_after_midrst";
        applyStimulus(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
